// File: rtl/pulse_request_arbiter_pkg.sv
// Shared definitions for the pulse request arbiter: FSM encoding and a
// constant clog2 helper for sizing channel indices.
`timescale 1ns/1ps
package pulse_request_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pulse_request_arbiter_edge.sv
// One button channel: multi-flop synchroniser followed by a rising-edge
// detector that emits a single-cycle pulse per press.
`timescale 1ns/1ps
module pulse_edge_channel
    import pulse_request_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_raw,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Only the synchronised level is compared, so holding the button never
    // produces more than one pulse.
    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pulse_request_arbiter.sv
// Shares one valid/ready command port between N button channels: latches
// each press as a pending request and issues them round-robin.
`timescale 1ns/1ps
module pulse_request_arbiter
    import pulse_request_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] btn,
    output logic             req_valid,
    output logic [ID_W-1:0]  req_id,
    input  logic             req_ready,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] overflow
);

    logic [N_REQ-1:0] pulse;
    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] pending_d;
    logic [N_REQ-1:0] overflow_q;
    logic [N_REQ-1:0] overflow_d;
    logic [N_REQ-1:0] xfer_mask;
    arb_state_e       state_q;
    logic             req_valid_q;
    logic [ID_W-1:0]  req_id_q;
    logic [ID_W-1:0]  last_grant_q;
    logic             transfer;
    logic             rr_found;
    logic [ID_W-1:0]  rr_id;
    logic [ID_W-1:0]  rr_cand;

    for (genvar i = 0; i < N_REQ; i++) begin : g_chan
        pulse_edge_channel #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clock  (clock),
            .reset_n(reset_n),
            .btn_raw(btn[i]),
            .pulse  (pulse[i])
        );
    end

    assign transfer = (state_q == ISSUE) && req_ready;

    always_comb begin
        xfer_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            xfer_mask[i] = transfer && (req_id_q == ID_W'(i));
        end
    end

    // A new pulse wins over the clear of the same edge; overflow only flags a
    // repeat press that lands while the request is still waiting.
    assign pending_d  = (pending_q & ~xfer_mask) | pulse;
    assign overflow_d = overflow_q | (pulse & pending_q & ~xfer_mask);

    always_comb begin
        rr_found = 1'b0;
        rr_id    = '0;
        rr_cand  = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            rr_cand = ID_W'((int'(last_grant_q) + off) % N_REQ);
            if (!rr_found && pending_q[rr_cand]) begin
                rr_found = 1'b1;
                rr_id    = rr_cand;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // last_grant resets to the top channel so channel 0 is searched first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            req_valid_q  <= 1'b0;
            req_id_q     <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (rr_found) begin
                        req_id_q    <= rr_id;
                        req_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (req_ready) begin
                        last_grant_q <= req_id_q;
                        req_valid_q  <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid = req_valid_q;
    assign req_id    = req_id_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_request_arbiter.sv
// Directed bench for pulse_request_arbiter: reset, latency, round-robin order,
// stall hold, overflow, set-wins-over-clear and glitch rejection.
`timescale 1ns/1ps
module tb_pulse_request_arbiter;

    logic       clock;
    logic       reset_n;
    logic [3:0] btn;
    logic       req_valid;
    logic [1:0] req_id;
    logic       req_ready;
    logic [3:0] pending;
    logic [3:0] overflow;

    int testCount = 0;
    int failCount = 0;
    int cyc = 0;
    int xferIds[$];
    int xferCyc[$];

    pulse_request_arbiter #(
        .N_REQ(4),
        .SYNC_STAGES(2),
        .ID_W(2)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn      (btn),
        .req_valid(req_valid),
        .req_id   (req_id),
        .req_ready(req_ready),
        .pending  (pending),
        .overflow (overflow)
    );

    initial begin
        clock = 1'b1;
        forever #10 clock = ~clock;
    end

    // Transfer log sampled 1ns before each rising edge, after inputs settle.
    always begin
        @(negedge clock);
        #9;
        cyc++;
        if (reset_n === 1'b1 && req_valid === 1'b1 && req_ready === 1'b1) begin
            xferIds.push_back(int'(req_id));
            xferCyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic goTo(input int k);
        longint target;
        target = 20 * k - 5;
        if ($time < target) #(target - $time);
    endtask

    task automatic applyStimulus(input logic [3:0] btnVal, input logic readyVal);
        btn       = btnVal;
        req_ready = readyVal;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int idAt(input int i);
        if (i < xferIds.size()) return xferIds[i];
        return 32'hFF;
    endfunction

    function automatic int gapAt(input int i);
        if (i + 1 < xferCyc.size()) return xferCyc[i+1] - xferCyc[i];
        return 32'hFF;
    endfunction

    initial begin
        reset_n = 1'b0;
        applyStimulus(4'b0000, 1'b0);

        goTo(2);
        checkOutput("rst_valid", 32'(req_valid), 0);
        checkOutput("rst_id", 32'(req_id), 0);
        checkOutput("rst_pending", 32'(pending), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        reset_n = 1'b1;

        // All channels pressed, then reset while a request is being offered.
        goTo(3);
        applyStimulus(4'b1111, 1'b0);
        goTo(6);
        checkOutput("lat_pending_all", 32'(pending), 32'hF);
        checkOutput("lat_valid_low", 32'(req_valid), 0);
        goTo(7);
        checkOutput("first_valid", 32'(req_valid), 1);
        checkOutput("first_id", 32'(req_id), 0);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(req_valid), 0);
        checkOutput("midrst_pending", 32'(pending), 0);
        checkOutput("midrst_overflow", 32'(overflow), 0);

        goTo(8);
        reset_n = 1'b1;
        applyStimulus(4'b1111, 1'b1);
        goTo(21);
        checkOutput("rr_count", 32'(xferIds.size()), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rr_id%0d", i), 32'(idAt(i)), 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rr_gap%0d", i), 32'(gapAt(i)), 2);
        end
        checkOutput("rr_pending_clear", 32'(pending), 0);
        checkOutput("rr_valid_low", 32'(req_valid), 0);
        applyStimulus(4'b0000, 1'b1);
        xferIds.delete();
        xferCyc.delete();

        goTo(26);
        checkOutput("fall_no_xfer", 32'(xferIds.size()), 0);
        checkOutput("fall_no_pending", 32'(pending), 0);

        // Single long press on channel 2.
        applyStimulus(4'b0100, 1'b1);
        goTo(29);
        checkOutput("ch2_pending", 32'(pending), 32'h4);
        checkOutput("ch2_valid_early", 32'(req_valid), 0);
        goTo(30);
        checkOutput("ch2_valid", 32'(req_valid), 1);
        checkOutput("ch2_id", 32'(req_id), 2);
        goTo(36);
        applyStimulus(4'b0000, 1'b1);
        goTo(40);
        checkOutput("ch2_count", 32'(xferIds.size()), 1);
        checkOutput("ch2_xfer_id", 32'(idAt(0)), 2);
        checkOutput("ch2_pending_clr", 32'(pending), 0);

        // Stalled channel 1 with a repeat press during the wait.
        xferIds.delete();
        xferCyc.delete();
        applyStimulus(4'b0010, 1'b0);
        goTo(42);
        applyStimulus(4'b0000, 1'b0);
        for (int k = 44; k < 54; k++) begin
            goTo(k);
            checkOutput($sformatf("stall_hold_c%0d", k), 32'({req_valid, req_id}), 32'b101);
            if (k == 46) applyStimulus(4'b0010, 1'b0);
            if (k == 48) applyStimulus(4'b0000, 1'b0);
        end
        goTo(54);
        checkOutput("stall_overflow", 32'(overflow), 32'h2);
        checkOutput("stall_pending", 32'(pending), 32'h2);
        checkOutput("stall_no_xfer", 32'(xferIds.size()), 0);
        applyStimulus(4'b0000, 1'b1);
        goTo(56);
        checkOutput("stall_count", 32'(xferIds.size()), 1);
        checkOutput("stall_xfer_id", 32'(idAt(0)), 1);
        checkOutput("stall_pending_clr", 32'(pending), 0);
        checkOutput("stall_overflow_sticky", 32'(overflow), 32'h2);

        // Channel 3 re-press whose pending-set coincides with its transfer edge.
        xferIds.delete();
        xferCyc.delete();
        applyStimulus(4'b1000, 1'b0);
        goTo(58);
        applyStimulus(4'b0000, 1'b0);
        goTo(60);
        checkOutput("ch3_valid_id", 32'({req_valid, req_id}), 32'b111);
        goTo(62);
        applyStimulus(4'b1000, 1'b0);
        goTo(64);
        checkOutput("ch3_pre_pending", 32'(pending), 32'h8);
        applyStimulus(4'b0000, 1'b1);
        goTo(65);
        checkOutput("setwins_pending", 32'(pending), 32'h8);
        checkOutput("setwins_overflow", 32'(overflow), 32'h2);
        checkOutput("setwins_valid_low", 32'(req_valid), 0);
        checkOutput("setwins_first", 32'(xferIds.size()), 1);
        goTo(66);
        checkOutput("setwins_reissue", 32'({req_valid, req_id}), 32'b111);
        goTo(68);
        checkOutput("setwins_count", 32'(xferIds.size()), 2);
        checkOutput("setwins_id2", 32'(idAt(1)), 3);
        checkOutput("setwins_pending_clr", 32'(pending), 0);

        // A 2ns glitch between edges is never sampled; the later press issues once.
        xferIds.delete();
        xferCyc.delete();
        #10 btn = 4'b0001;
        #2  btn = 4'b0000;
        goTo(70);
        applyStimulus(4'b0001, 1'b1);
        goTo(73);
        applyStimulus(4'b0000, 1'b1);
        goTo(80);
        checkOutput("glitch_count", 32'(xferIds.size()), 1);
        checkOutput("glitch_id", 32'(idAt(0)), 0);
        checkOutput("glitch_pending", 32'(pending), 0);
        checkOutput("glitch_overflow", 32'(overflow), 32'h2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
